// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register file and its sequential reader.
// Optional build macro REGFILE_READER_PARITY_EN adds a parity bit to the reader output.
package regfile_pkg;

  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_t;

  function automatic logic word_parity(input logic [RF_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready output register with a load enable; the caller loads only when the slot is free.
module stream_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_payload
);

  logic         valid_q;
  logic [W-1:0] payload_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (load) begin
      valid_q   <= 1'b1;
      payload_q <= load_data;
    end else if (out_ready) begin
      // A transfer with no new capture empties the slot; payload is left as-is.
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/regfile_reader.sv
// Sweeps a register-file read port over [first_addr..last_addr] and streams words out.
// Build macro REGFILE_READER_PARITY_EN adds out_parity = ^out_data.
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned WIDTH = RF_WIDTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    first_addr,
  input  logic [AW-1:0]    last_addr,
  output logic [AW-1:0]    rf_addr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             busy,
  output logic             done
`ifdef REGFILE_READER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

`ifdef REGFILE_READER_PARITY_EN
  localparam int unsigned PW = AW + WIDTH + 1;
`else
  localparam int unsigned PW = AW + WIDTH;
`endif

  rd_state_t     state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] last_q, last_d;
  logic          done_q, done_d;
  logic          load;
  logic [PW-1:0] load_data;
  logic [PW-1:0] payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (first_addr <= last_addr) begin
            cur_d   = first_addr;
            last_d  = last_addr;
            state_d = RUN;
          end else begin
            // Empty range: report completion without touching the read pointer.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!out_valid || out_ready) begin
          load = 1'b1;
          // Stop on the compare so a sweep ending at DEPTH-1 never wraps cur.
          if (cur_q == last_q) begin
            state_d = DRAIN;
          end else begin
            cur_d = cur_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REGFILE_READER_PARITY_EN
  assign load_data  = {cur_q, rf_rdata, ^rf_rdata};
  assign out_parity = payload[0];
  assign out_data   = payload[WIDTH:1];
  assign out_addr   = payload[PW-1:WIDTH+1];
`else
  assign load_data  = {cur_q, rf_rdata};
  assign out_data   = payload[WIDTH-1:0];
  assign out_addr   = payload[PW-1:WIDTH];
`endif

  stream_out_reg #(
    .W(PW)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_payload(payload)
  );

  assign rf_addr = cur_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule
